// File: rtl/aes_pkg.sv
// Shared ShiftRows helpers: per-row rotate amounts, legal block widths and
// the (row, col) -> bit offset mapping of the state vector.
package aes_pkg;

  localparam int ROWS = 4;

  // Rijndael row rotate: rows 2/3 move one further when the block is 256 bits wide.
  function automatic int shift_off(input int nb, input int row);
    if (nb == 8 && row >= 2) return row + 1;
    return row;
  endfunction

  function automatic bit nb_legal(input int nb);
    return (nb == 4) || (nb == 6) || (nb == 8);
  endfunction

  function automatic int byte_idx(input int col, input int row);
    return 32 * col + 8 * row;
  endfunction

endpackage

// File: rtl/shift_rows_perm.sv
// Combinational forward/inverse ShiftRows byte permutation for NB columns.
// With SHIFT_ROWS_PIPE_BYPASS_EN an identity bypass overrides the direction.
module shift_rows_perm
  import aes_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic            inv,
`ifdef SHIFT_ROWS_PIPE_BYPASS_EN
  input  logic            bypass,
`endif
  input  logic [32*NB-1:0] s,
  output logic [32*NB-1:0] p
);

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < NB; c++) begin : g_col
      localparam int OFF = shift_off(NB, r);
      localparam int FWD = byte_idx((c + OFF) % NB, r);
      localparam int INV = byte_idx((c + NB - OFF) % NB, r);
      localparam int DST = byte_idx(c, r);
      logic [7:0] perm_b;

      // Pure wiring per byte; row 0 folds to a straight connection.
      assign perm_b = inv ? s[INV +: 8] : s[FWD +: 8];
`ifdef SHIFT_ROWS_PIPE_BYPASS_EN
      assign p[DST +: 8] = bypass ? s[DST +: 8] : perm_b;
`else
      assign p[DST +: 8] = perm_b;
`endif
    end
  end

endmodule

// File: rtl/shift_rows_pipe.sv
// Elastic ShiftRows stage: permute on entry, then PIPE_STAGES valid/ready registers.
// Optional identity bypass port enabled by SHIFT_ROWS_PIPE_BYPASS_EN.
module shift_rows_pipe
  import aes_pkg::*;
#(
  parameter int NB          = 4,
  parameter int PIPE_STAGES = 1,
  parameter int TAG_W       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_inv_flag,
`ifdef SHIFT_ROWS_PIPE_BYPASS_EN
  input  logic              in_bypass,
`endif
  input  logic [TAG_W-1:0]  in_tag,
  input  logic [32*NB-1:0]  in_s,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [TAG_W-1:0]  out_tag,
  output logic [32*NB-1:0]  out_s
);

  localparam int SW   = 32 * NB;
  localparam int LAST = PIPE_STAGES - 1;

  if (!nb_legal(NB)) begin : g_bad_nb
    $error("shift_rows_pipe: NB must be 4, 6 or 8");
  end
  if (PIPE_STAGES < 1 || PIPE_STAGES > 3) begin : g_bad_depth
    $error("shift_rows_pipe: PIPE_STAGES must be 1..3");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("shift_rows_pipe: TAG_W must be at least 1");
  end

  logic [SW-1:0]                   perm_s;
  logic [PIPE_STAGES-1:0]          v;
  logic [PIPE_STAGES-1:0]          ld;
  logic [PIPE_STAGES-1:0][SW-1:0]  s_q;
  logic [PIPE_STAGES-1:0][TAG_W-1:0] tag_q;
  logic                            down;

  shift_rows_perm #(.NB(NB)) u_perm (
    .inv    (in_inv_flag),
`ifdef SHIFT_ROWS_PIPE_BYPASS_EN
    .bypass (in_bypass),
`endif
    .s      (in_s),
    .p      (perm_s)
  );

  // Ready ripples back from the output: a stage may load if empty or if it drains.
  always_comb begin
    ld   = '0;
    down = out_ready;
    for (int k = LAST; k >= 0; k--) begin
      ld[k] = !v[k] || down;
      down  = ld[k];
    end
  end

  for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
    logic             v_in, v_r;
    logic [SW-1:0]    s_in, s_r;
    logic [TAG_W-1:0] t_in, t_r;

    if (k == 0) begin : g_head
      assign v_in = in_valid;
      assign s_in = perm_s;
      assign t_in = in_tag;
    end else begin : g_body
      assign v_in = v[k-1];
      assign s_in = s_q[k-1];
      assign t_in = tag_q[k-1];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v_r <= 1'b0;
        s_r <= '0;
        t_r <= '0;
      end else if (ld[k]) begin
        v_r <= v_in;
        if (v_in) begin
          s_r <= s_in;
          t_r <= t_in;
        end
      end
    end

    assign v[k]     = v_r;
    assign s_q[k]   = s_r;
    assign tag_q[k] = t_r;
  end

  assign in_ready  = ld[0];
  assign out_valid = v[LAST];
  assign out_s     = s_q[LAST];
  assign out_tag   = tag_q[LAST];

endmodule
